// File: rtl/gravity_div_ctrl.sv
// Centroid divide sequencer: latches the gravity sums and computes X = SX/S, then Y = SY/S on one restoring divider.
// Latency: 2*DW clocks from start acceptance to oVALID (S==0 short-cuts to DONE on the accepting edge).
// Backpressure: the result is held with oVALID/oBUSY high until iACK; starts arriving while busy are dropped and flagged.
module gravity_div_ctrl #(
   parameter int SUM_S_WIDTH  = 20,
   parameter int SUM_SX_WIDTH = 28,
   parameter int SUM_SY_WIDTH = 28,
   parameter int Q_WIDTH      = 11
) (
   input  logic                    CCLK,
   input  logic                    RST_N,
   input  logic                    iSTART,
   input  logic [SUM_S_WIDTH-1:0]  iSUM_S,
   input  logic [SUM_SX_WIDTH-1:0] iSUM_SX,
   input  logic [SUM_SY_WIDTH-1:0] iSUM_SY,
   output logic                    oBUSY,
   output logic                    oVALID,
   input  logic                    iACK,
   output logic [Q_WIDTH-1:0]      oX,
   output logic [Q_WIDTH-1:0]      oY,
   output logic                    oNODATA,
   output logic                    oSAT,
   output logic                    oOVERRUN
);

   localparam int DW = (SUM_SX_WIDTH > SUM_SY_WIDTH) ? SUM_SX_WIDTH : SUM_SY_WIDTH;
   localparam int CW = (DW > 1) ? $clog2(DW) : 1;
   localparam int RW = SUM_S_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

   state_t                 state, state_nxt;
   logic [SUM_S_WIDTH-1:0] sum_s, sum_s_nxt;
   logic [DW-1:0]          sum_sx, sum_sx_nxt;
   logic [DW-1:0]          sum_sy, sum_sy_nxt;
   logic [RW-1:0]          rem, rem_nxt;
   // The last quotient bit is produced on the storing step itself, so only DW-1 bits are registered.
   logic [DW-2:0]          quo, quo_nxt;
   logic [CW-1:0]          cnt, cnt_nxt;
   logic [Q_WIDTH-1:0]     x_nxt, y_nxt;
   logic                   nodata_nxt, sat_nxt, valid_nxt, busy_nxt, overrun_nxt;

   logic [DW-1:0]          dividend;
   logic [RW-1:0]          shifted;
   logic                   take;
   logic [RW-1:0]          rem_step;
   logic [DW-1:0]          q_full;
   logic                   q_over;
   logic [Q_WIDTH-1:0]     q_clip;

   // One restoring step: shift in the next dividend bit and subtract the divisor when it fits.
   // A set remainder MSB would be shifted out, so the shifted value must exceed the divisor.
   assign dividend = (state == DIV_Y) ? sum_sy : sum_sx;
   assign shifted  = {rem[RW-2:0], dividend[cnt]};
   assign take     = rem[RW-1] | (shifted >= {1'b0, sum_s});
   assign rem_step = take ? (shifted - {1'b0, sum_s}) : shifted;
   assign q_full   = {quo, take};
   assign q_over   = |q_full[DW-1:Q_WIDTH];
   assign q_clip   = q_over ? {Q_WIDTH{1'b1}} : q_full[Q_WIDTH-1:0];

   // Next-state and next-output decode; every register holds unless a state says otherwise.
   always_comb begin
      state_nxt   = state;
      sum_s_nxt   = sum_s;
      sum_sx_nxt  = sum_sx;
      sum_sy_nxt  = sum_sy;
      rem_nxt     = rem;
      quo_nxt     = quo;
      cnt_nxt     = cnt;
      x_nxt       = oX;
      y_nxt       = oY;
      nodata_nxt  = oNODATA;
      sat_nxt     = oSAT;
      valid_nxt   = oVALID;
      busy_nxt    = oBUSY;
      overrun_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (iSTART) begin
               sum_s_nxt  = iSUM_S;
               sum_sx_nxt = DW'(iSUM_SX);
               sum_sy_nxt = DW'(iSUM_SY);
               busy_nxt   = 1'b1;
               nodata_nxt = 1'b0;
               sat_nxt    = 1'b0;
               rem_nxt    = '0;
               quo_nxt    = '0;
               cnt_nxt    = CW'(DW - 1);
               if (iSUM_S == '0) begin
                  nodata_nxt = 1'b1;
                  x_nxt      = '0;
                  y_nxt      = '0;
                  valid_nxt  = 1'b1;
                  state_nxt  = DONE;
               end else begin
                  state_nxt  = DIV_X;
               end
            end
         end
         DIV_X: begin
            overrun_nxt = iSTART;
            rem_nxt     = rem_step;
            quo_nxt     = q_full[DW-2:0];
            cnt_nxt     = cnt - 1'b1;
            if (cnt == '0) begin
               x_nxt     = q_clip;
               sat_nxt   = q_over;
               rem_nxt   = '0;
               quo_nxt   = '0;
               cnt_nxt   = CW'(DW - 1);
               state_nxt = DIV_Y;
            end
         end
         DIV_Y: begin
            overrun_nxt = iSTART;
            rem_nxt     = rem_step;
            quo_nxt     = q_full[DW-2:0];
            cnt_nxt     = cnt - 1'b1;
            if (cnt == '0) begin
               y_nxt     = q_clip;
               sat_nxt   = oSAT | q_over;
               valid_nxt = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            overrun_nxt = iSTART;
            if (iACK) begin
               valid_nxt = 1'b0;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt  = IDLE;
            sum_s_nxt  = '0;
            sum_sx_nxt = '0;
            sum_sy_nxt = '0;
            rem_nxt    = '0;
            quo_nxt    = '0;
            cnt_nxt    = '0;
            x_nxt      = '0;
            y_nxt      = '0;
            nodata_nxt = 1'b0;
            sat_nxt    = 1'b0;
            valid_nxt  = 1'b0;
            busy_nxt   = 1'b0;
         end
      endcase
   end

   // State, datapath and registered outputs; reset aborts any division in flight.
   always_ff @(posedge CCLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= IDLE;
         sum_s    <= '0;
         sum_sx   <= '0;
         sum_sy   <= '0;
         rem      <= '0;
         quo      <= '0;
         cnt      <= '0;
         oX       <= '0;
         oY       <= '0;
         oNODATA  <= 1'b0;
         oSAT     <= 1'b0;
         oVALID   <= 1'b0;
         oBUSY    <= 1'b0;
         oOVERRUN <= 1'b0;
      end else begin
         state    <= state_nxt;
         sum_s    <= sum_s_nxt;
         sum_sx   <= sum_sx_nxt;
         sum_sy   <= sum_sy_nxt;
         rem      <= rem_nxt;
         quo      <= quo_nxt;
         cnt      <= cnt_nxt;
         oX       <= x_nxt;
         oY       <= y_nxt;
         oNODATA  <= nodata_nxt;
         oSAT     <= sat_nxt;
         oVALID   <= valid_nxt;
         oBUSY    <= busy_nxt;
         oOVERRUN <= overrun_nxt;
      end
   end

endmodule
